// File: rtl/id_ex_pipe_reg_if.sv
// RV32I control-word package and the decode/execute slot interface.
// The same bundle carries the decode slot into the register and the EX slot out of it.
package rv32i_pkg;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_CSR   = 7'b1110011;

   typedef struct packed {
      logic [6:0] opcode;
      logic [2:0] funct3;
      logic [3:0] alu_op;
      logic       alu_src_imm;
      logic       load_regfile;
      logic       data_mem_read;
      logic       data_mem_write;
      logic       branch;
      logic       jump;
   } rv32i_control_word;

   // Bubble: opcode zero, no regfile or memory side effects.
   localparam rv32i_control_word CTRL_BUBBLE = '0;
endpackage

interface id_ex_pipe_reg_if #(
   parameter int XLEN = 32
);
   import rv32i_pkg::*;

   logic              valid;
   logic              ready;
   rv32i_control_word ctrl;
   logic [XLEN-1:0]   pc;
   logic [XLEN-1:0]   instr;
   logic [4:0]        rs1_idx;
   logic [4:0]        rs2_idx;
   logic [4:0]        rd_idx;
   logic [XLEN-1:0]   rs1_data;
   logic [XLEN-1:0]   rs2_data;

   modport master (
      output valid, ctrl, pc, instr,
      output rs1_idx, rs2_idx, rd_idx,
      output rs1_data, rs2_data,
      input  ready
   );

   modport slave (
      input  valid, ctrl, pc, instr,
      input  rs1_idx, rs2_idx, rd_idx,
      input  rs1_data, rs2_data,
      output ready
   );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// Decode->execute pipeline register with load-use bubble, flush and stall counter.
// Define ID_EX_WB_BYPASS_EN to forward same-cycle WB data into captured operands.
module id_ex_pipe_reg
   import rv32i_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   id_ex_pipe_reg_if.slave  id,
   id_ex_pipe_reg_if.master ex,
   input  logic             wb_load,
   input  logic [4:0]       wb_rd,
   input  logic [XLEN-1:0]  wb_data,
   input  logic             flush,
   output logic             load_use_stall,
   output logic [CNT_W-1:0] stall_cycles
);

   logic              valid_q;
   rv32i_control_word ctrl_q;
   logic [XLEN-1:0]   pc_q;
   logic [XLEN-1:0]   instr_q;
   logic [4:0]        rs1_idx_q;
   logic [4:0]        rs2_idx_q;
   logic [4:0]        rd_q;
   logic [XLEN-1:0]   rs1_q;
   logic [XLEN-1:0]   rs2_q;
   logic [CNT_W-1:0]  cnt_q;

   logic            advance;
   logic            rs1_used;
   logic            rs2_used;
   logic            ex_is_load;
   logic            rs1_hit;
   logic            rs2_hit;
   logic            do_bubble;
   logic            do_capture;
   logic [XLEN-1:0] rs1_cap;
   logic [XLEN-1:0] rs2_cap;

   assign advance = !valid_q | ex.ready;

   assign rs1_used = !(id.ctrl.opcode inside
                       {OP_LUI, OP_AUIPC, OP_JAL});
   assign rs2_used = id.ctrl.opcode inside
                     {OP_BR, OP_STORE, OP_REG};

   assign ex_is_load = valid_q
                     & ctrl_q.data_mem_read
                     & ctrl_q.load_regfile
                     & (rd_q != 5'd0);

   assign rs1_hit = rs1_used & (id.rs1_idx == rd_q);
   assign rs2_hit = rs2_used & (id.rs2_idx == rd_q);

   assign load_use_stall = id.valid & ex_is_load
                         & (rs1_hit | rs2_hit);

   assign id.ready = flush | (advance & !load_use_stall);

   // Exactly one of bubble/capture/hold per edge.
   assign do_bubble  = flush
                     | (advance & (load_use_stall | !id.valid));
   assign do_capture = !flush & advance
                     & !load_use_stall & id.valid;

`ifdef ID_EX_WB_BYPASS_EN
   logic wb_hit;
   assign wb_hit  = wb_load & (wb_rd != 5'd0);
   assign rs1_cap = (wb_hit & (wb_rd == id.rs1_idx))
                  ? wb_data : id.rs1_data;
   assign rs2_cap = (wb_hit & (wb_rd == id.rs2_idx))
                  ? wb_data : id.rs2_data;
`else
   logic unused_wb;
   assign unused_wb = ^{wb_load, wb_rd, wb_data};
   assign rs1_cap   = id.rs1_data;
   assign rs2_cap   = id.rs2_data;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         ctrl_q    <= CTRL_BUBBLE;
         pc_q      <= '0;
         instr_q   <= '0;
         rs1_idx_q <= '0;
         rs2_idx_q <= '0;
         rd_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
      end else begin
         unique case (1'b1)
            do_bubble: begin
               valid_q <= 1'b0;
               ctrl_q  <= CTRL_BUBBLE;
            end
            do_capture: begin
               valid_q   <= 1'b1;
               ctrl_q    <= id.ctrl;
               pc_q      <= id.pc;
               instr_q   <= id.instr;
               rs1_idx_q <= id.rs1_idx;
               rs2_idx_q <= id.rs2_idx;
               rd_q      <= id.rd_idx;
               rs1_q     <= rs1_cap;
               rs2_q     <= rs2_cap;
            end
            default: begin
            end
         endcase
      end
   end

   // Counts every hazard cycle, including stalled and flushed ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load_use_stall && !(&cnt_q)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign stall_cycles = cnt_q;

   assign ex.valid    = valid_q;
   assign ex.ctrl     = ctrl_q;
   assign ex.pc       = pc_q;
   assign ex.instr    = instr_q;
   assign ex.rs1_idx  = rs1_idx_q;
   assign ex.rs2_idx  = rs2_idx_q;
   assign ex.rd_idx   = rd_q;
   assign ex.rs1_data = rs1_q;
   assign ex.rs2_data = rs2_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: reference model plus directed hazard/flush/bypass vectors.
// Honours ID_EX_WB_BYPASS_EN for the bypass expectations.
module tb_id_ex_pipe_reg;
   import rv32i_pkg::*;

   localparam int XLEN    = 32;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef ID_EX_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             wb_load;
   logic [4:0]       wb_rd;
   logic [XLEN-1:0]  wb_data;
   logic             flush;
   logic             load_use_stall;
   logic [CNT_W-1:0] stall_cycles;

   id_ex_pipe_reg_if #(.XLEN(XLEN)) id_bus ();
   id_ex_pipe_reg_if #(.XLEN(XLEN)) ex_bus ();

   id_ex_pipe_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .id             (id_bus.slave),
      .ex             (ex_bus.master),
      .wb_load        (wb_load),
      .wb_rd          (wb_rd),
      .wb_data        (wb_data),
      .flush          (flush),
      .load_use_stall (load_use_stall),
      .stall_cycles   (stall_cycles)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(string name, logic [63:0] act,
                      logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
      end
   endtask

   // Reference model: the instruction occupying the EX slot.
   logic              m_valid;
   rv32i_control_word m_ctrl;
   logic [31:0]       m_pc, m_instr, m_d1, m_d2;
   logic [4:0]        m_r1, m_r2, m_rd;
   int                m_cnt;

   function automatic bit reads_rs1(logic [6:0] op);
      return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
   endfunction

   function automatic bit reads_rs2(logic [6:0] op);
      return op == OP_BR || op == OP_STORE || op == OP_REG;
   endfunction

   function automatic bit m_stall();
      bit pending_load;
      pending_load = m_valid && m_ctrl.data_mem_read
                  && m_ctrl.load_regfile && m_rd != 0;
      return id_bus.valid && pending_load &&
             ((reads_rs1(id_bus.ctrl.opcode) &&
               id_bus.rs1_idx == m_rd) ||
              (reads_rs2(id_bus.ctrl.opcode) &&
               id_bus.rs2_idx == m_rd));
   endfunction

   function automatic logic [31:0] m_src(logic [4:0] idx,
                                         logic [31:0] d);
      if (BYP && wb_load && wb_rd != 0 && wb_rd == idx)
         return wb_data;
      return d;
   endfunction

   initial begin : model
      bit st, adv;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_valid = 0; m_ctrl = '0; m_cnt = 0;
            m_pc = 0; m_instr = 0; m_d1 = 0; m_d2 = 0;
            m_r1 = 0; m_r2 = 0; m_rd = 0;
         end else begin
            st  = m_stall();
            adv = !m_valid || ex_bus.ready;
            if (st && m_cnt < CNT_MAX) m_cnt++;
            if (flush || (adv && (st || !id_bus.valid))) begin
               m_valid = 0;
               m_ctrl  = '0;
            end else if (adv) begin
               m_valid = 1;
               m_ctrl  = id_bus.ctrl;
               m_pc    = id_bus.pc;
               m_instr = id_bus.instr;
               m_r1    = id_bus.rs1_idx;
               m_r2    = id_bus.rs2_idx;
               m_rd    = id_bus.rd_idx;
               m_d1    = m_src(id_bus.rs1_idx, id_bus.rs1_data);
               m_d2    = m_src(id_bus.rs2_idx, id_bus.rs2_data);
            end
         end
      end
   end

   initial begin : compare
      bit exp_rdy;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            exp_rdy = flush ||
                      ((!m_valid || ex_bus.ready) && !m_stall());
            chk("m_ex_valid", ex_bus.valid, m_valid);
            chk("m_ex_ctrl", ex_bus.ctrl, m_ctrl);
            chk("m_stall", load_use_stall, m_stall());
            chk("m_id_ready", id_bus.ready, exp_rdy);
            chk("m_cnt", stall_cycles, m_cnt);
            if (m_valid) begin
               chk("m_pc", ex_bus.pc, m_pc);
               chk("m_instr", ex_bus.instr, m_instr);
               chk("m_rs1_idx", ex_bus.rs1_idx, m_r1);
               chk("m_rs2_idx", ex_bus.rs2_idx, m_r2);
               chk("m_rd", ex_bus.rd_idx, m_rd);
               chk("m_rs1_data", ex_bus.rs1_data, m_d1);
               chk("m_rs2_data", ex_bus.rs2_data, m_d2);
            end
         end
      end
   end

   function automatic rv32i_control_word mk_ctrl(logic [6:0] op);
      rv32i_control_word c;
      c = '0;
      c.opcode         = op;
      c.load_regfile   = !(op == OP_BR || op == OP_STORE);
      c.data_mem_read  = (op == OP_LOAD);
      c.data_mem_write = (op == OP_STORE);
      c.branch         = (op == OP_BR);
      c.jump           = (op == OP_JAL || op == OP_JALR);
      c.alu_src_imm    = !(op == OP_REG || op == OP_BR);
      return c;
   endfunction

   task automatic issue(logic [6:0] op, logic [31:0] pc,
                        logic [31:0] ins, logic [4:0] r1,
                        logic [4:0] r2, logic [4:0] rd,
                        logic [31:0] d1, logic [31:0] d2);
      id_bus.valid    = 1'b1;
      id_bus.ctrl     = mk_ctrl(op);
      id_bus.pc       = pc;
      id_bus.instr    = ins;
      id_bus.rs1_idx  = r1;
      id_bus.rs2_idx  = r2;
      id_bus.rd_idx   = rd;
      id_bus.rs1_data = d1;
      id_bus.rs2_data = d2;
   endtask

   task automatic next();
      @(posedge clk);
      #2;
   endtask

   localparam logic [31:0] I_ADD  = 32'h003100B3;
   localparam logic [31:0] I_SUB  = 32'h40628233;
   localparam logic [31:0] I_LW5  = 32'h0000A283;
   localparam logic [31:0] I_DEP  = 32'h00728333;
   localparam logic [31:0] I_LW0  = 32'h00002003;
   localparam logic [31:0] I_ADD0 = 32'h00700333;
   localparam logic [31:0] I_LUI  = 32'h123452B7;
   localparam logic [31:0] I_SW   = 32'h00512023;
   localparam logic [31:0] I_XOR  = 32'h00B54533;

   initial begin
      rst_n = 1'b0; flush = 1'b0;
      wb_load = 1'b0; wb_rd = '0; wb_data = '0;
      ex_bus.ready = 1'b1;
      id_bus.valid = 1'b0; id_bus.ctrl = '0;
      id_bus.pc = '0; id_bus.instr = '0;
      id_bus.rs1_idx = '0; id_bus.rs2_idx = '0;
      id_bus.rd_idx = '0;
      id_bus.rs1_data = '0; id_bus.rs2_data = '0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_ex_valid", ex_bus.valid, 1'b0);
      chk("rst_cnt", stall_cycles, 0);
      chk("rst_id_ready", id_bus.ready, 1'b1);
      rst_n = 1'b1;

      // back-to-back add / sub
      issue(OP_REG, 32'h100, I_ADD, 2, 3, 1, 32'h22, 32'h33);
      next();
      chk("b2b_add_valid", ex_bus.valid, 1'b1);
      chk("b2b_add_instr", ex_bus.instr, I_ADD);
      chk("b2b_add_pc", ex_bus.pc, 32'h100);
      issue(OP_REG, 32'h104, I_SUB, 5, 6, 4, 32'h55, 32'h66);
      next();
      chk("b2b_sub_valid", ex_bus.valid, 1'b1);
      chk("b2b_sub_instr", ex_bus.instr, I_SUB);
      chk("b2b_sub_rs2", ex_bus.rs2_data, 32'h66);
      chk("b2b_cnt", stall_cycles, 0);

      // load-use on rs1
      issue(OP_LOAD, 32'h108, I_LW5, 1, 0, 5, 32'h11, 32'h0);
      next();
      issue(OP_REG, 32'h10C, I_DEP, 5, 7, 6, 32'h55, 32'h77);
      #1;
      chk("lu_stall", load_use_stall, 1'b1);
      chk("lu_id_ready", id_bus.ready, 1'b0);
      next();
      chk("lu_bubble", ex_bus.valid, 1'b0);
      chk("lu_bubble_ld", ex_bus.ctrl.load_regfile, 1'b0);
      chk("lu_cnt", stall_cycles, 1);
      chk("lu_clear", load_use_stall, 1'b0);
      next();
      chk("lu_captured", ex_bus.instr, I_DEP);
      chk("lu_cap_valid", ex_bus.valid, 1'b1);

      // rd = x0 never stalls
      issue(OP_LOAD, 32'h110, I_LW0, 0, 0, 0, 32'h0, 32'h0);
      next();
      issue(OP_REG, 32'h114, I_ADD0, 0, 7, 6, 32'h0, 32'h77);
      #1;
      chk("x0_no_stall", load_use_stall, 1'b0);
      next();
      chk("x0_captured", ex_bus.instr, I_ADD0);
      chk("x0_cnt", stall_cycles, 1);

      // lui does not read rs1; sw reads rs2
      issue(OP_LOAD, 32'h118, I_LW5, 1, 0, 5, 32'h11, 32'h0);
      next();
      issue(OP_LUI, 32'h11C, I_LUI, 5, 5, 5, 32'h0, 32'h0);
      #1;
      chk("lui_no_stall", load_use_stall, 1'b0);
      next();
      chk("lui_captured", ex_bus.instr, I_LUI);
      issue(OP_LOAD, 32'h120, I_LW5, 1, 0, 5, 32'h11, 32'h0);
      next();
      issue(OP_STORE, 32'h124, I_SW, 2, 5, 0, 32'h2000, 32'h55);
      #1;
      chk("sw_stall", load_use_stall, 1'b1);
      next();
      chk("sw_bubble", ex_bus.valid, 1'b0);
      chk("sw_cnt", stall_cycles, 2);
      next();
      chk("sw_captured", ex_bus.instr, I_SW);

      // flush coinciding with a load-use stall
      issue(OP_LOAD, 32'h128, I_LW5, 1, 0, 5, 32'h11, 32'h0);
      next();
      issue(OP_REG, 32'h12C, I_DEP, 5, 7, 6, 32'h55, 32'h77);
      flush = 1'b1;
      #1;
      chk("fl_stall", load_use_stall, 1'b1);
      chk("fl_id_ready", id_bus.ready, 1'b1);
      next();
      chk("fl_killed", ex_bus.valid, 1'b0);
      chk("fl_cnt", stall_cycles, 3);
      flush = 1'b0;

      // flush while EX is blocked
      issue(OP_REG, 32'h130, I_ADD, 2, 3, 1, 32'h22, 32'h33);
      next();
      chk("fb_valid", ex_bus.valid, 1'b1);
      ex_bus.ready = 1'b0;
      flush = 1'b1;
      issue(OP_REG, 32'h134, I_XOR, 10, 11, 10, 32'h1, 32'h2);
      #1;
      chk("fb_id_ready", id_bus.ready, 1'b1);
      next();
      chk("fb_killed", ex_bus.valid, 1'b0);
      flush = 1'b0;
      id_bus.valid = 1'b0;
      ex_bus.ready = 1'b1;
      next();
      chk("fb_never", ex_bus.valid, 1'b0);

      // stall while EX is blocked, then saturation
      issue(OP_LOAD, 32'h138, I_LW5, 1, 0, 5, 32'h11, 32'h0);
      next();
      ex_bus.ready = 1'b0;
      issue(OP_REG, 32'h13C, I_DEP, 5, 7, 6, 32'h55, 32'h77);
      next();
      next();
      chk("hold_instr", ex_bus.instr, I_LW5);
      chk("hold_valid", ex_bus.valid, 1'b1);
      chk("hold_cnt", stall_cycles, 5);
      repeat (12) next();
      chk("sat_cnt", stall_cycles, CNT_MAX);
      ex_bus.ready = 1'b1;
      next();
      chk("rel_bubble", ex_bus.valid, 1'b0);
      next();
      chk("rel_captured", ex_bus.instr, I_DEP);
      chk("pre_rst_valid", ex_bus.valid, 1'b1);

      // asynchronous reset mid-stream
      rst_n = 1'b0;
      #1;
      chk("ar_valid", ex_bus.valid, 1'b0);
      chk("ar_ld", ex_bus.ctrl.load_regfile, 1'b0);
      chk("ar_cnt", stall_cycles, 0);
      next();
      rst_n = 1'b1;

      // write-back bypass
      wb_load = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
      issue(OP_REG, 32'h200, I_ADD, 3, 4, 1, 32'h0, 32'h44);
      next();
      chk("byp_rs1", ex_bus.rs1_data,
          BYP ? 32'hDEADBEEF : 32'h0);
      chk("byp_rs1_other", ex_bus.rs2_data, 32'h44);
      issue(OP_REG, 32'h204, I_ADD, 4, 3, 1, 32'h44, 32'h0);
      next();
      chk("byp_rs2", ex_bus.rs2_data,
          BYP ? 32'hDEADBEEF : 32'h0);
      wb_rd = 5'd0;
      issue(OP_REG, 32'h208, I_ADD, 0, 0, 1, 32'h0, 32'h0);
      next();
      chk("byp_x0", ex_bus.rs1_data, 32'h0);
      wb_load = 1'b0;
      id_bus.valid = 1'b0;
      next();
      next();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
